// File: rtl/lc3_pkg.sv
// Shared constants and field-select encoding for the LC-3 immediate/offset generator.
package lc3_pkg;
  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_IMM5    = 3'd0,
    SEL_OFF6    = 3'd1,
    SEL_PCOFF9  = 3'd2,
    SEL_PCOFF11 = 3'd3,
    SEL_TRAP8   = 3'd4,
    SEL_ZERO    = 3'd5
  } sel_e;

  localparam int W_IMM5    = 5;
  localparam int W_OFF6    = 6;
  localparam int W_PCOFF9  = 9;
  localparam int W_PCOFF11 = 11;
  localparam int W_TRAP8   = 8;
endpackage

// File: rtl/lc3_field_ext.sv
// Combinational field extractor: picks an instruction field and extends it to DATA_W.
module lc3_field_ext
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       in_instr,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [DATA_W-1:0] ext,
  output logic              err
);

  // Widest field is 11 bits, so DATA_W >= 11 keeps every shift below in range.
  function automatic logic [DATA_W-1:0] sext(input logic [15:0] v, input int w);
    logic [DATA_W-1:0] x;
    int sh;
    sh       = DATA_W - w;
    x        = '0;
    x[10:0]  = v[10:0];
    x        = x << sh;
    return $unsigned($signed(x) >>> sh);
  endfunction

  function automatic logic [DATA_W-1:0] zext(input logic [15:0] v, input int w);
    logic [DATA_W-1:0] x;
    int sh;
    sh       = DATA_W - w;
    x        = '0;
    x[10:0]  = v[10:0];
    return (x << sh) >> sh;
  endfunction

  always_comb begin
    ext = '0;
    err = 1'b0;
    case (in_sel)
      SEL_IMM5:    ext = sext(in_instr, W_IMM5);
      SEL_OFF6:    ext = sext(in_instr, W_OFF6);
      SEL_PCOFF9:  ext = sext(in_instr, W_PCOFF9);
      SEL_PCOFF11: ext = sext(in_instr, W_PCOFF11);
      SEL_TRAP8:   ext = zext(in_instr, W_TRAP8);
      SEL_ZERO:    ext = '0;
      default:     err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_imm_ext_pipe.sv
// Two-stage extend/add pipe with valid/ready handshake between the IR and the address/ALU muxes.
module lc3_imm_ext_pipe #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = lc3_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_add,
  input  logic [DATA_W-1:0] in_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] w_ext;
  logic              w_err;
  logic              w_s1_load;
  logic              w_s2_load;

  logic [2:1]        r_vld_pipe;
  logic [DATA_W-1:0] r_s1_ext;
  logic [DATA_W-1:0] r_s1_base;
  logic              r_s1_add;
  logic              r_s1_err;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_err;
  logic              r_err_sticky;

  lc3_field_ext #(.DATA_W(DATA_W)) u_field_ext (
    .in_instr (in_instr),
    .in_sel   (in_sel),
    .ext      (w_ext),
    .err      (w_err)
  );

  // S1 may accept whenever it is empty or will drain into S2 this cycle.
  assign in_ready  = !r_vld_pipe[1] | !r_vld_pipe[2] | out_ready;
  assign w_s1_load = in_valid & in_ready;
  assign w_s2_load = r_vld_pipe[1] & (!r_vld_pipe[2] | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe   <= '0;
      r_s1_ext     <= '0;
      r_s1_base    <= '0;
      r_s1_add     <= 1'b0;
      r_s1_err     <= 1'b0;
      r_s2_data    <= '0;
      r_s2_err     <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_vld_pipe[1] <= 1'b1;
        r_s1_ext      <= w_ext;
        r_s1_base     <= in_base;
        r_s1_add      <= in_add;
        r_s1_err      <= w_err;
      end else if (w_s2_load) begin
        r_vld_pipe[1] <= 1'b0;
      end

      if (w_s2_load) begin
        r_vld_pipe[2] <= 1'b1;
        r_s2_data     <= r_s1_add ? r_s1_ext + r_s1_base : r_s1_ext;
        r_s2_err      <= r_s1_err;
      end else if (r_vld_pipe[2] & out_ready) begin
        r_vld_pipe[2] <= 1'b0;
      end

      if (w_s1_load & w_err) r_err_sticky <= 1'b1;
    end
  end

  assign out_valid  = r_vld_pipe[2];
  assign out_data   = r_s2_data;
  assign out_err    = r_s2_err;
  assign err_sticky = r_err_sticky;
  assign occupancy  = {1'b0, r_vld_pipe[1]} + {1'b0, r_vld_pipe[2]};

endmodule

// File: tb/tb_lc3_imm_ext_pipe.sv
// Scoreboarded bench for lc3_imm_ext_pipe: directed field/add cases, backpressure, resets, random traffic.
module tb_lc3_imm_ext_pipe;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_instr = '0;
  logic [2:0]    in_sel = '0;
  logic          in_add = 1'b0;
  logic [DW-1:0] in_base = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          err_sticky;
  logic [1:0]    occupancy;

  int n_pass = 0;
  int n_total = 0;
  int n_out = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [DW-1:0] last_data;
  logic          last_err;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  lc3_imm_ext_pipe #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_add(in_add), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .err_sticky(err_sticky), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(logic [15:0] ins, logic [2:0] sel, logic add, logic [DW-1:0] base);
    exp_t r;
    logic [DW-1:0] e;
    e = '0;
    r.err = 1'b0;
    case (sel)
      3'd0: e = {{11{ins[4]}}, ins[4:0]};
      3'd1: e = {{10{ins[5]}}, ins[5:0]};
      3'd2: e = {{7{ins[8]}}, ins[8:0]};
      3'd3: e = {{5{ins[10]}}, ins[10:0]};
      3'd4: e = {8'h00, ins[7:0]};
      3'd5: e = '0;
      default: r.err = 1'b1;
    endcase
    r.data = add ? e + base : e;
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        n_total++;
        if (out_data !== prev_data) $display("FAIL stall_hold: out_data %h, required %h", out_data, prev_data);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        exp_t e;
        n_total++;
        n_out++;
        last_data = out_data;
        last_err  = out_err;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_out: out_data %h with empty scoreboard, required no output", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_err !== e.err)
            $display("FAIL sb_compare: got data %h err %b, required data %h err %b", out_data, out_err, e.data, e.err);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_instr, in_sel, in_add, in_base));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send(input logic [15:0] ins, input logic [2:0] sel, input logic add,
                      input logic [DW-1:0] base, output int waited);
    in_instr = ins; in_sel = sel; in_add = add; in_base = base; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready %b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((sb.size() != 0 || occupancy != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (sb.size() != 0 || occupancy !== 2'd0)
      $display("FAIL drain: %0d pending, occupancy %0d, required 0/0", sb.size(), occupancy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int w;
    rst_n = 1'b0;
    #12;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || err_sticky !== 1'b0 ||
        occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL reset_state: ov %b od %h oe %b es %b occ %0d ir %b, required 0 0000 0 0 0 1",
               out_valid, out_data, out_err, err_sticky, occupancy, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h0005, 3'd0, 1'b0, '0, w);
    n_total++;
    if (w != 0) $display("FAIL first_accept: waited %0d cycles, required 0", w);
    else n_pass++;
    drain();
  endtask

  task automatic test_sign_ext();
    int w;
    out_ready = 1'b1;
    send(16'h003F, 3'd1, 1'b0, '0, w);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL latency_early: out_valid %b, required 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF)
      $display("FAIL off6_neg: out_valid %b out_data %h, required 1 ffff", out_valid, out_data);
    else n_pass++;
    drain();
    send(16'h001F, 3'd1, 1'b0, '0, w); drain();
    n_total++;
    if (last_data !== 16'h001F) $display("FAIL off6_pos: out_data %h, required 001f", last_data);
    else n_pass++;
    send(16'h0010, 3'd0, 1'b0, '0, w); drain();
    n_total++;
    if (last_data !== 16'hFFF0) $display("FAIL imm5_neg: out_data %h, required fff0", last_data);
    else n_pass++;
    send(16'h0400, 3'd3, 1'b0, '0, w); drain();
    n_total++;
    if (last_data !== 16'hFC00) $display("FAIL pcoff11_neg: out_data %h, required fc00", last_data);
    else n_pass++;
  endtask

  task automatic test_add_wrap();
    int w;
    send(16'h01FF, 3'd2, 1'b1, 16'h3000, w); drain();
    n_total++;
    if (last_data !== 16'h2FFF) $display("FAIL add_base3000: out_data %h, required 2fff", last_data);
    else n_pass++;
    send(16'h01FF, 3'd2, 1'b1, 16'h0000, w); drain();
    n_total++;
    if (last_data !== 16'hFFFF) $display("FAIL add_base0: out_data %h, required ffff", last_data);
    else n_pass++;
    send(16'h003F, 3'd1, 1'b1, 16'h0001, w); drain();
    n_total++;
    if (last_data !== 16'h0000) $display("FAIL add_wrap: out_data %h, required 0000", last_data);
    else n_pass++;
  endtask

  task automatic test_trap8_zero();
    int w;
    send(16'hF0A5, 3'd4, 1'b0, '0, w); drain();
    n_total++;
    if (last_data !== 16'h00A5) $display("FAIL trap8: out_data %h, required 00a5", last_data);
    else n_pass++;
    send(16'hFFFF, 3'd5, 1'b1, 16'h1234, w); drain();
    n_total++;
    if (last_data !== 16'h1234 || err_sticky !== 1'b0)
      $display("FAIL zero_add: out_data %h err_sticky %b, required 1234 0", last_data, err_sticky);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w, n0;
    exp_t a;
    a = model(16'h0001, 3'd1, 1'b0, '0);
    n0 = n_out;
    out_ready = 1'b0;
    send(16'h0001, 3'd1, 1'b0, '0, w);
    send(16'h0002, 3'd1, 1'b0, '0, w);
    in_instr = 16'h0003; in_sel = 3'd1; in_add = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== a.data)
        $display("FAIL bp_full: ir %b occ %0d ov %b od %h, required 0 2 1 %h",
                 in_ready, occupancy, out_valid, out_data, a.data);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h0003, 3'd1, 1'b0, '0, w);
    send(16'h0004, 3'd1, 1'b0, '0, w);
    drain();
    n_total++;
    if (n_out - n0 != 4 || last_data !== 16'h0004)
      $display("FAIL bp_count: %0d results, last %h, required 4 0004", n_out - n0, last_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w, c0;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(16'($urandom), 3'($urandom_range(0, 5)), 1'($urandom), 16'($urandom), w);
    n_total++;
    if (cyc - c0 != 16) $display("FAIL throughput: %0d cycles for 16 requests, required 16", cyc - c0);
    else n_pass++;
    drain();
  endtask

  task automatic test_reserved();
    int w;
    n_total++;
    if (err_sticky !== 1'b0) $display("FAIL sticky_pre: err_sticky %b, required 0", err_sticky);
    else n_pass++;
    send(16'hABCD, 3'd6, 1'b0, 16'h5555, w); drain();
    n_total++;
    if (last_data !== 16'h0000 || last_err !== 1'b1 || err_sticky !== 1'b1)
      $display("FAIL reserved6: data %h err %b sticky %b, required 0000 1 1", last_data, last_err, err_sticky);
    else n_pass++;
    send(16'h0001, 3'd0, 1'b0, '0, w);
    send(16'h1234, 3'd7, 1'b1, 16'h0042, w);
    drain();
    n_total++;
    if (err_sticky !== 1'b1 || last_err !== 1'b1)
      $display("FAIL sticky_hold: err_sticky %b last_err %b, required 1 1", err_sticky, last_err);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (err_sticky !== 1'b0) $display("FAIL sticky_clear: err_sticky %b, required 0", err_sticky);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midstream();
    int w, n0;
    out_ready = 1'b0;
    send(16'h0011, 3'd0, 1'b0, '0, w);
    send(16'h0012, 3'd0, 1'b0, '0, w);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: ov %b occ %0d ir %b, required 0 0 1", out_valid, occupancy, in_ready);
    else n_pass++;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (n_out != n0 || out_valid !== 1'b0)
      $display("FAIL stale_out: %0d results ov %b after reset, required 0 0", n_out - n0, out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int w, n0;
    bit done;
    done = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), w);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    n_total++;
    if (n_out - n0 != 30) $display("FAIL random_count: %0d results, required 30", n_out - n0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_add_wrap();
    test_trap8_zero();
    test_backpressure();
    test_back_to_back();
    test_reserved();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
